bmu: RTL and testbench
======================

BMU -- requirements
Module: bmu

Interface
- Parameters: none; all widths fixed.
- REQ-001: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-002: rst_ni  input  1  synchronous reset, active-low, sampled on rising clk_i.
- REQ-003: piso_data_i  input  2  received hard-decision symbol pair from the PISO stage.
- REQ-004: piso_valid_i  input  1  qualifies piso_data_i for the current cycle.
- REQ-005: bm_s0_s0_o  output  2  branch metric, transition S0->S0, expected codeword 00.
- REQ-006: bm_s0_s2_o  output  2  branch metric, S0->S2, codeword 11.
- REQ-007: bm_s1_s0_o  output  2  branch metric, S1->S0, codeword 11.
- REQ-008: bm_s1_s2_o  output  2  branch metric, S1->S2, codeword 00.
- REQ-009: bm_s2_s1_o  output  2  branch metric, S2->S1, codeword 10.
- REQ-010: bm_s2_s3_o  output  2  branch metric, S2->S3, codeword 01.
- REQ-011: bm_s3_s1_o  output  2  branch metric, S3->S1, codeword 01.
- REQ-012: bm_s3_s3_o  output  2  branch metric, S3->S3, codeword 10.
- REQ-013: bm_valid_o  output  1  high when the bm_* outputs hold metrics of a newly accepted symbol.

Function
- REQ-014: Each branch metric SHALL be the Hamming distance between piso_data_i and the transition's codeword: popcount(piso_data_i XOR codeword), range 0..2.
- REQ-015: Bit i of piso_data_i SHALL be compared with bit i of the codeword, i.e. codeword 10 means bit1=1, bit0=0.
- REQ-016: Metric encoding SHALL be unsigned binary: 00=0, 01=1, 10=2; value 11 SHALL never be produced.
- REQ-017: All bm_* outputs and bm_valid_o SHALL be registered, with a latency of exactly 1 clk_i cycle from a sampled piso_valid_i=1 to bm_valid_o=1 with the matching metrics.
- REQ-018: When piso_valid_i=1 on a rising edge, all eight metrics SHALL update from piso_data_i, and bm_valid_o SHALL be 1 in the following cycle.
- REQ-019: When piso_valid_i=0 on a rising edge, the metrics SHALL hold their previous values, and bm_valid_o SHALL be 0 in the following cycle.
- REQ-020: Back-to-back valid symbols SHALL be accepted every cycle, with no stall and no backpressure.
- REQ-021: Complementary branches SHALL sum to 2 for every input: s0_s0+s0_s2, s1_s0+s1_s2, s2_s1+s2_s3, s3_s1+s3_s3.
- REQ-022: Pairs sharing a codeword SHALL be equal: s0_s0=s1_s2, s0_s2=s1_s0, s2_s1=s3_s3, s2_s3=s3_s1.
- REQ-023: X/undefined piso_data_i while piso_valid_i=0 SHALL NOT affect any output.

Reset
- REQ-024: While rst_ni=0 at a rising edge, all bm_* outputs SHALL become 0 and bm_valid_o SHALL become 0, regardless of piso_valid_i.
- REQ-025: When reset is asserted mid-stream, the pending symbol SHALL be discarded; after rst_ni returns to 1, the first valid symbol SHALL appear 1 cycle after acceptance.
- REQ-026: Outputs SHALL be undefined only before the first reset edge; no asynchronous path from rst_ni to the outputs SHALL exist.

Verification
- REQ-027: Input 00 valid -> next cycle s0_s0=0, s0_s2=2, s1_s2=0, s1_s0=2, s2_s1=1, s2_s3=1, s3_s1=1, s3_s3=1, bm_valid_o=1.
- REQ-028: Input 11 valid -> s0_s0=2, s0_s2=0, s1_s2=2, s1_s0=0, s2_s*/s3_* all 1.
- REQ-029: Input 10 valid -> s2_s1=0, s2_s3=2, s3_s1=2, s3_s3=0, s0_*/s1_* all 1.
- REQ-030: Input 01 valid -> s2_s1=2, s2_s3=0, s3_s1=0, s3_s3=2.
- REQ-031: Input 00, then 11 valid on consecutive cycles, then piso_valid_i=0 with data 10 -> metrics for 00, then 11, then held 11 values with bm_valid_o=0.
- REQ-032: rst_ni=0 for one edge during a valid stream -> all outputs 0 next cycle; the stream resumes correctly afterwards; REQ-021/022 invariants are checked on every valid cycle.

Source files
------------

// File: rtl/bmu.sv
// Branch metric unit for a 4-state rate-1/2 Viterbi decoder.
// Registers the Hamming distance between each received symbol pair and every trellis branch codeword.
module bmu (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] piso_data_i,
  input  logic       piso_valid_i,
  output logic [1:0] bm_s0_s0_o,
  output logic [1:0] bm_s0_s2_o,
  output logic [1:0] bm_s1_s0_o,
  output logic [1:0] bm_s1_s2_o,
  output logic [1:0] bm_s2_s1_o,
  output logic [1:0] bm_s2_s3_o,
  output logic [1:0] bm_s3_s1_o,
  output logic [1:0] bm_s3_s3_o,
  output logic       bm_valid_o
);

  // Only four distinct codewords exist, so four distances cover all eight branches.
  logic [1:0] dist_00, dist_01, dist_10, dist_11;

  logic [1:0] bm_s0_s0_q, bm_s0_s2_q, bm_s1_s0_q, bm_s1_s2_q;
  logic [1:0] bm_s2_s1_q, bm_s2_s3_q, bm_s3_s1_q, bm_s3_s3_q;
  logic [1:0] bm_s0_s0_d, bm_s0_s2_d, bm_s1_s0_d, bm_s1_s2_d;
  logic [1:0] bm_s2_s1_d, bm_s2_s3_d, bm_s3_s1_d, bm_s3_s3_d;
  logic       bm_valid_q, bm_valid_d;

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction

  always_comb begin
    dist_00 = hamming2(piso_data_i, 2'b00);
    dist_01 = hamming2(piso_data_i, 2'b01);
    dist_10 = hamming2(piso_data_i, 2'b10);
    dist_11 = hamming2(piso_data_i, 2'b11);
  end

  always_comb begin
    bm_s0_s0_d = bm_s0_s0_q;
    bm_s0_s2_d = bm_s0_s2_q;
    bm_s1_s0_d = bm_s1_s0_q;
    bm_s1_s2_d = bm_s1_s2_q;
    bm_s2_s1_d = bm_s2_s1_q;
    bm_s2_s3_d = bm_s2_s3_q;
    bm_s3_s1_d = bm_s3_s1_q;
    bm_s3_s3_d = bm_s3_s3_q;
    bm_valid_d = piso_valid_i;
    // Data is ignored entirely when not valid, so undefined inputs cannot leak through.
    if (piso_valid_i) begin
      bm_s0_s0_d = dist_00;
      bm_s0_s2_d = dist_11;
      bm_s1_s0_d = dist_11;
      bm_s1_s2_d = dist_00;
      bm_s2_s1_d = dist_10;
      bm_s2_s3_d = dist_01;
      bm_s3_s1_d = dist_01;
      bm_s3_s3_d = dist_10;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bm_s0_s0_q <= 2'd0;
      bm_s0_s2_q <= 2'd0;
      bm_s1_s0_q <= 2'd0;
      bm_s1_s2_q <= 2'd0;
      bm_s2_s1_q <= 2'd0;
      bm_s2_s3_q <= 2'd0;
      bm_s3_s1_q <= 2'd0;
      bm_s3_s3_q <= 2'd0;
      bm_valid_q <= 1'b0;
    end else begin
      bm_s0_s0_q <= bm_s0_s0_d;
      bm_s0_s2_q <= bm_s0_s2_d;
      bm_s1_s0_q <= bm_s1_s0_d;
      bm_s1_s2_q <= bm_s1_s2_d;
      bm_s2_s1_q <= bm_s2_s1_d;
      bm_s2_s3_q <= bm_s2_s3_d;
      bm_s3_s1_q <= bm_s3_s1_d;
      bm_s3_s3_q <= bm_s3_s3_d;
      bm_valid_q <= bm_valid_d;
    end
  end

  assign bm_s0_s0_o = bm_s0_s0_q;
  assign bm_s0_s2_o = bm_s0_s2_q;
  assign bm_s1_s0_o = bm_s1_s0_q;
  assign bm_s1_s2_o = bm_s1_s2_q;
  assign bm_s2_s1_o = bm_s2_s1_q;
  assign bm_s2_s3_o = bm_s2_s3_q;
  assign bm_s3_s1_o = bm_s3_s1_q;
  assign bm_s3_s3_o = bm_s3_s3_q;
  assign bm_valid_o = bm_valid_q;

endmodule

// File: tb/tb_bmu.sv
// Bench for bmu: directed trellis vectors, mid-stream reset and random traffic against a
// popcount-based reference model of the eight branch metrics.
module tb_bmu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] data;
  logic       valid;
  logic [1:0] bm [8];
  logic       bm_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  // Branch order: s0s0, s0s2, s1s0, s1s2, s2s1, s2s3, s3s1, s3s3.
  logic [1:0] codeword [8] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};
  string      name     [8] = '{"s0_s0", "s0_s2", "s1_s0", "s1_s2",
                               "s2_s1", "s2_s3", "s3_s1", "s3_s3"};
  int exp_bm [8];
  int exp_valid;

  always #5 clk = ~clk;

  bmu dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .piso_data_i (data),
    .piso_valid_i(valid),
    .bm_s0_s0_o  (bm[0]),
    .bm_s0_s2_o  (bm[1]),
    .bm_s1_s0_o  (bm[2]),
    .bm_s1_s2_o  (bm[3]),
    .bm_s2_s1_o  (bm[4]),
    .bm_s2_s3_o  (bm[5]),
    .bm_s3_s1_o  (bm[6]),
    .bm_s3_s3_o  (bm[7]),
    .bm_valid_o  (bm_valid)
  );

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input logic rst, input logic v, input logic [1:0] d, input string tag);
    rst_n = rst;
    valid = v;
    data  = d;
    @(posedge clk);
    if (!rst) begin
      foreach (exp_bm[i]) exp_bm[i] = 0;
      exp_valid = 0;
    end else if (v) begin
      foreach (exp_bm[i]) exp_bm[i] = $countones(d ^ codeword[i]);
      exp_valid = 1;
    end else begin
      exp_valid = 0;
    end
    #1;
    for (int i = 0; i < 8; i++) check($sformatf("%s.%s", tag, name[i]), int'(bm[i]), exp_bm[i]);
    check($sformatf("%s.valid", tag), int'(bm_valid), exp_valid);
    if (exp_valid == 1) begin
      check($sformatf("%s.sum0", tag), int'(bm[0]) + int'(bm[1]), 2);
      check($sformatf("%s.sum1", tag), int'(bm[2]) + int'(bm[3]), 2);
      check($sformatf("%s.sum2", tag), int'(bm[4]) + int'(bm[5]), 2);
      check($sformatf("%s.sum3", tag), int'(bm[6]) + int'(bm[7]), 2);
      check($sformatf("%s.eqA", tag), int'(bm[0]), int'(bm[3]));
      check($sformatf("%s.eqB", tag), int'(bm[1]), int'(bm[2]));
      check($sformatf("%s.eqC", tag), int'(bm[4]), int'(bm[7]));
      check($sformatf("%s.eqD", tag), int'(bm[5]), int'(bm[6]));
    end
    @(negedge clk);
  endtask

  initial begin
    logic       r;
    logic       v;
    logic [1:0] d;
    rst_n = 1'b0;
    valid = 1'b1;
    data  = 2'b11;
    foreach (exp_bm[i]) exp_bm[i] = 0;
    exp_valid = 0;
    @(negedge clk);

    // Reset wins over a valid input.
    step(1'b0, 1'b1, 2'b11, "rst");
    step(1'b0, 1'b0, 2'b00, "rst2");

    // Single valid symbols for each codeword.
    step(1'b1, 1'b1, 2'b00, "in00");
    step(1'b1, 1'b1, 2'b11, "in11");
    step(1'b1, 1'b1, 2'b10, "in10");
    step(1'b1, 1'b1, 2'b01, "in01");
    step(1'b1, 1'b0, 2'b00, "idle");

    // Back-to-back 00, 11, then hold with data 10 and undefined data.
    step(1'b1, 1'b1, 2'b00, "seq00");
    step(1'b1, 1'b1, 2'b11, "seq11");
    step(1'b1, 1'b0, 2'b10, "hold10");
    step(1'b1, 1'b0, 2'bxx, "holdx");

    // Mid-stream reset discards the pending symbol, stream resumes next cycle.
    step(1'b1, 1'b1, 2'b10, "pre");
    step(1'b0, 1'b1, 2'b01, "midrst");
    step(1'b1, 1'b1, 2'b01, "resume");
    step(1'b1, 1'b1, 2'b11, "resume2");

    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 19) != 0);
      v = ($urandom_range(0, 3) != 0);
      d = 2'($urandom_range(0, 3));
      step(r, v, d, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
